// File: rtl/haze_stream_framer.sv
// Framing stage ahead of the haze-removal core: buffers BGR pixels, regenerates TLAST
// from the frame geometry and tracks which of the two passes the output beat belongs to.
`timescale 1ns/1ps
module haze_stream_framer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        enable,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic        pass,
    output logic        frame_done,
    output logic        err_len,
    output logic        busy
);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int IW   = (PIX > 1) ? $clog2(PIX) : 1;

    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [IW-1:0]   IN_LAST  = IW'(PIX - 1);

    typedef enum logic {
        ST_ALE = 1'b0,
        ST_TE  = 1'b1
    } pass_state_e;

    logic [23:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [IW-1:0]   in_cnt_q, in_cnt_d;
    pass_state_e     state_q, state_d;
    logic            frame_done_q, frame_done_d;
    logic            err_len_q, err_len_d;
    logic            busy_q, busy_d;

    logic s_ready, m_valid, s_hs, m_hs, at_last;
    logic unused_upper;

    assign unused_upper = ^S_AXIS_TDATA[31:24];

    // ARESETn gates TREADY so no beat is offered as accepted while reset is held.
    assign s_ready = enable & ARESETn & (count_q < DEPTH_C);
    assign m_valid = enable & (count_q != '0);
    assign s_hs    = S_AXIS_TVALID & s_ready;
    assign m_hs    = m_valid & M_AXIS_TREADY;
    assign at_last = (col_q == COL_LAST) & (row_q == ROW_LAST);

    assign S_AXIS_TREADY = s_ready;
    assign M_AXIS_TVALID = m_valid;
    assign M_AXIS_TLAST  = m_valid & at_last;
    assign M_AXIS_TDATA  = m_valid ? {8'h00, mem[rd_ptr_q]} : 32'h0;
    assign pass          = state_q;
    assign frame_done    = frame_done_q;
    assign err_len       = err_len_q;
    assign busy          = busy_q;

    always_ff @(posedge ACLK) begin
        if (s_hs) begin
            mem[wr_ptr_q] <= S_AXIS_TDATA[23:0];
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        col_d        = col_q;
        row_d        = row_q;
        in_cnt_d     = in_cnt_q;
        state_d      = state_q;
        frame_done_d = 1'b0;
        err_len_d    = err_len_q;

        if (s_hs) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (m_hs) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({s_hs, m_hs})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (m_hs) begin
            if (at_last) begin
                col_d        = '0;
                row_d        = '0;
                frame_done_d = 1'b1;
                state_d      = (state_q == ST_ALE) ? ST_TE : ST_ALE;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // Source TLAST only realigns the input counter; the output side never sees it.
        if (s_hs) begin
            if (S_AXIS_TLAST && (in_cnt_q != IN_LAST)) begin
                err_len_d = 1'b1;
            end
            if (S_AXIS_TLAST || (in_cnt_q == IN_LAST)) begin
                in_cnt_d = '0;
            end else begin
                in_cnt_d = in_cnt_q + 1'b1;
            end
        end

        busy_d = (count_q != '0) | (col_q != '0) | (row_q != '0);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            in_cnt_q     <= '0;
            state_q      <= ST_ALE;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            col_q        <= col_d;
            row_q        <= row_d;
            in_cnt_q     <= in_cnt_d;
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            err_len_q    <= err_len_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_haze_stream_framer.sv
// Directed bench for haze_stream_framer on a 4x2 frame with a 4-entry FIFO.
`timescale 1ns/1ps
module tb_haze_stream_framer;
    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        pass;
    logic        frame_done;
    logic        err_len;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int s_acc    = 0;
    int fd_cnt   = 0;
    int base;

    logic [31:0] q_data [$];
    logic        q_last [$];
    logic        q_pass [$];

    always #5 clk = ~clk;

    haze_stream_framer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .FIFO_DEPTH(D)
    ) dut (
        .ACLK         (clk),
        .ARESETn      (rst_n),
        .enable       (enable),
        .S_AXIS_TDATA (s_tdata),
        .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TLAST (s_tlast),
        .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA (m_tdata),
        .M_AXIS_TVALID(m_tvalid),
        .M_AXIS_TLAST (m_tlast),
        .M_AXIS_TREADY(m_tready),
        .pass         (pass),
        .frame_done   (frame_done),
        .err_len      (err_len),
        .busy         (busy)
    );

    // Inputs change just after posedge, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_last.push_back(m_tlast);
            q_pass.push_back(pass);
        end
        if (s_tvalid && s_tready) s_acc++;
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int t = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_tready) check("push_timeout", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sready"}, 32'(s_tready), 32'd0);
        check({tag, "_mvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_mlast"}, 32'(m_tlast), 32'd0);
        check({tag, "_mdata"}, m_tdata, 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_fdone"}, 32'(frame_done), 32'd0);
        check({tag, "_err"}, 32'(err_len), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] first, input logic exp_pass);
        logic [31:0] d;
        logic        l;
        logic        p;
        check({tag, "_nbeats"}, 32'(q_data.size()), 32'd8);
        for (int i = 0; i < 8 && q_data.size() > 0; i++) begin
            d = q_data.pop_front();
            l = q_last.pop_front();
            p = q_pass.pop_front();
            $display("%s beat %0d data=%h last=%0b pass=%0b", tag, i, d, l, p);
            check($sformatf("%s_data%0d", tag, i), d, first + 32'(i));
            check($sformatf("%s_last%0d", tag, i), 32'(l), 32'(i == 7));
            check($sformatf("%s_pass%0d", tag, i), 32'(p), 32'(exp_pass));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        #12;
        check_idle("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("sready_after_reset", 32'(s_tready), 32'd1);

        // Basic frame with single-cycle latency
        push(32'h1, 1'b0);
        check("latency_valid", 32'(m_tvalid), 32'd1);
        check("latency_data", m_tdata, 32'h1);
        for (int i = 2; i <= 8; i++) push(32'(i), i == 8);
        settle();
        check_frame("f1", 32'h1, 1'b0);
        check("f1_fdone", 32'(fd_cnt), 32'd1);
        check("f1_pass", 32'(pass), 32'd1);
        check("f1_busy", 32'(busy), 32'd0);

        // Second frame on the TE pass
        for (int i = 0; i < 8; i++) push(32'h11 + 32'(i), i == 7);
        settle();
        check_frame("f2", 32'h11, 1'b1);
        check("f2_fdone", 32'(fd_cnt), 32'd2);
        check("f2_pass", 32'(pass), 32'd0);

        // Backpressure: FIFO fills to depth then stalls the source
        m_tready = 1'b0;
        base = s_acc;
        fork
            begin
                for (int i = 0; i < 8; i++) push(32'h21 + 32'(i), i == 7);
            end
            begin
                repeat (10) @(posedge clk);
                #2;
                check("bp_accepted", 32'(s_acc - base), 32'd4);
                check("bp_sready", 32'(s_tready), 32'd0);
                check("bp_mvalid", 32'(m_tvalid), 32'd1);
                check("bp_head", m_tdata, 32'h21);
                check("bp_busy", 32'(busy), 32'd1);
                check("bp_no_output", 32'(q_data.size()), 32'd0);
                m_tready = 1'b1;
            end
        join
        settle();
        check_frame("f3", 32'h21, 1'b0);
        check("f3_accepted", 32'(s_acc - base), 32'd8);
        check("f3_fdone", 32'(fd_cnt), 32'd3);
        check("f3_err", 32'(err_len), 32'd0);

        // Early source TLAST on the third beat
        for (int i = 0; i < 8; i++) begin
            push(32'h31 + 32'(i), i == 2);
            if (i == 2) check("f4_err_set", 32'(err_len), 32'd1);
        end
        settle();
        check_frame("f4", 32'h31, 1'b1);
        check("f4_err_sticky", 32'(err_len), 32'd1);
        check("f4_pass", 32'(pass), 32'd0);

        // Enable dropped after five beats, then resumed
        for (int i = 0; i < 5; i++) push(32'h41 + 32'(i), 1'b0);
        settle();
        enable   = 1'b0;
        s_tdata  = 32'h46;
        s_tvalid = 1'b1;
        base     = s_acc;
        repeat (5) @(posedge clk);
        #1;
        check("en_sready", 32'(s_tready), 32'd0);
        check("en_mvalid", 32'(m_tvalid), 32'd0);
        check("en_accepted", 32'(s_acc - base), 32'd0);
        check("en_outputs", 32'(q_data.size()), 32'd5);
        check("en_pass", 32'(pass), 32'd0);
        check("en_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        push(32'h46, 1'b0);
        push(32'h47, 1'b0);
        push(32'h48, 1'b1);
        settle();
        check_frame("f5", 32'h41, 1'b0);
        check("f5_fdone", 32'(fd_cnt), 32'd5);
        check("f5_pass", 32'(pass), 32'd1);

        // Asynchronous reset mid-frame with data still buffered
        for (int i = 0; i < 5; i++) push(32'h51 + 32'(i), 1'b0);
        settle();
        q_data.delete();
        q_last.delete();
        q_pass.delete();
        m_tready = 1'b0;
        push(32'h56, 1'b0);
        push(32'h57, 1'b0);
        check("pre_rst_mvalid", 32'(m_tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_tready = 1'b1;
        base     = fd_cnt;
        for (int i = 0; i < 8; i++) push(32'h61 + 32'(i), i == 7);
        settle();
        check_frame("f6", 32'h61, 1'b0);
        check("f6_fdone", 32'(fd_cnt - base), 32'd1);
        check("f6_pass", 32'(pass), 32'd1);
        check("f6_err", 32'(err_len), 32'd0);

        // Upper byte is stripped on the way through
        m_tready = 1'b0;
        push(32'hFF123456, 1'b0);
        check("upper_valid", 32'(m_tvalid), 32'd1);
        check("upper_data", m_tdata, 32'h00123456);
        m_tready = 1'b1;
        settle();
        check("upper_nbeats", 32'(q_data.size()), 32'd1);
        if (q_data.size() > 0) check("upper_out", q_data.pop_front(), 32'h00123456);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/haze_stream_framer.md
# haze_stream_framer

Upstream framing stage for `Haze_Removal_Top`. It accepts raw 24-bit BGR pixels on an AXI4-Stream slave and buffers them in a small FIFO. It forwards them to the haze-removal core with TLAST generated from the configured frame geometry. It also tracks which of the two passes is in progress: pass 0 feeds ALE, pass 1 feeds TE/SRSC. This removes any dependence on the source driving TLAST or on external pass bookkeeping.

## Interface
Parameters:
- `IMG_WIDTH`, 512, pixels per row.
- `IMG_HEIGHT`, 512, rows per frame.
- `FIFO_DEPTH`, 4, buffer entries; power of two, minimum 2.

Ports:
- `ACLK`  in  1  single clock; all logic on rising edge.
- `ARESETn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global run enable.
- `S_AXIS_TDATA`  in  32  pixel: [7:0] B, [15:8] G, [23:16] R, [31:24] ignored.
- `S_AXIS_TVALID`  in  1  source beat valid.
- `S_AXIS_TLAST`  in  1  optional source end-of-frame; checked only, never forwarded.
- `S_AXIS_TREADY`  out  1  block can accept.
- `M_AXIS_TDATA`  out  32  pixel to core; [31:24] forced 0.
- `M_AXIS_TVALID`  out  1  output beat valid.
- `M_AXIS_TLAST`  out  1  last pixel of frame.
- `M_AXIS_TREADY`  in  1  core ready.
- `pass`  out  1  0 = ALE pass, 1 = TE/SRSC pass; applies to the beat currently at the output.
- `frame_done`  out  1  one-cycle pulse after the last beat of a frame transfers.
- `err_len`  out  1  sticky; set when the source raises TLAST before the last pixel.
- `busy`  out  1  FIFO non-empty or output frame counters non-zero.

## Operation
**FIFO**
- Circular buffer with `FIFO_DEPTH` entries.
- Write on S handshake (`S_AXIS_TVALID & S_AXIS_TREADY`).
- Read on M handshake (`M_AXIS_TVALID & M_AXIS_TREADY`).
- Occupancy count is width clog2(FIFO_DEPTH)+1.
- `S_AXIS_TREADY = enable & (count < FIFO_DEPTH)`.
- When full, simultaneous read and write is not permitted: TREADY is already low.
- Read and write on the same cycle when not full and not empty: count unchanged.

**Output**
- `M_AXIS_TVALID = enable & (count != 0)`.
- TDATA = {8'h00, head[23:0]}.

**Output frame counters**
- `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) advance only on M handshake.
- `col` wraps to 0 and increments `row`.
- `M_AXIS_TLAST = M_AXIS_TVALID & (col == IMG_WIDTH-1) & (row == IMG_HEIGHT-1)`.

**Pass FSM**
- States: `ALE` (reset state, `pass` = 0) and `TE` (`pass` = 1).
- The M handshake with TLAST does three things: toggles the state (ALE→TE, TE→ALE), clears `col`/`row`, and asserts `frame_done` on the next cycle.
- No other transitions.

**Input check**
- Independent input counter `in_cnt` (0..W*H-1) advances on S handshake and wraps at W*H-1.
- S handshake with `S_AXIS_TLAST = 1` and `in_cnt != W*H-1` sets `err_len`; `in_cnt` then resets to 0.
- Missing TLAST on the final pixel is not an error.
- `err_len` clears only on reset.

**`enable` low**
- Both TREADY and TVALID are 0; FIFO contents, counters and FSM hold.
- Deasserting `enable` mid-frame resumes exactly where the frame stopped.

**Reset (asynchronous, any time, including mid-frame)**
- FIFO emptied; `col`, `row`, `in_cnt` cleared; FSM to `ALE`.
- Values while `ARESETn` is low: `S_AXIS_TREADY` 0, `M_AXIS_TVALID` 0, `M_AXIS_TLAST` 0, `M_AXIS_TDATA` 0, `pass` 0, `frame_done` 0, `err_len` 0, `busy` 0.

## Timing
- Latency: a beat written at edge N is presented with TVALID high after edge N (available at edge N+1); minimum 1 cycle.
- Throughput: 1 beat/cycle sustained with `M_AXIS_TREADY` = 1.
- No combinational path from `M_AXIS_TREADY` to `S_AXIS_TREADY`; TREADY depends on registered count and `enable` only.
- AXI rules:
  - Once asserted, `M_AXIS_TVALID`, TDATA and TLAST stay stable until handshake (`enable` low is the only exception).
  - `frame_done` goes high the cycle after the TLAST handshake, for exactly one cycle.
  - `pass` changes on the same edge that `frame_done` rises.
- `busy` is registered and falls the cycle after the FIFO empties with `col` = `row` = 0.

## Test plan
Use W=4, H=2, FIFO_DEPTH=4 (8 px/frame) unless stated.

1. **Basic frame.** Reset, then stream 8 pixels 0x000001..0x000008 with M_TREADY=1.
   - Outputs in order, each 1 cycle after acceptance.
   - TLAST only on 0x000008.
   - `frame_done` pulses once; `pass` goes 0→1.
2. **Second frame.** Stream another 8 pixels.
   - `pass` = 1 on all 8 beats; TLAST on the 8th; `pass` returns to 0.
   - After two frames, `frame_done` has pulsed exactly twice.
3. **Backpressure.** Hold M_TREADY=0 for 10 cycles while the source is valid.
   - Exactly 4 beats accepted, then S_TREADY=0.
   - Releasing M_TREADY drains in order with no loss or duplication.
4. **Early TLAST.** Source TLAST on the 3rd input beat.
   - `err_len` = 1 and stays 1.
   - Output TLAST is still on the 8th output beat.
5. **Enable and reset mid-frame.**
   - Drop `enable` after 5 beats: no handshakes and state held. Restore: TLAST on beat 8.
   - Pulse ARESETn low after 5 beats: all outputs 0 immediately. The next frame starts at `pass` = 0 and needs 8 beats to reach TLAST.
6. **Upper byte.** Input TDATA 0xFF123456 → output TDATA 0x00123456.
